// File: rtl/memref_model_mp.sv
// Multi-read-port, single-write-port memory model: per-port read-latency pipeline, sticky
// error flags, saturating counters. Define MEMREF_MODEL_MP_BYPASS_EN for write-first forwarding.
module memref_model_mp #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned RD_PORTS   = 2,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic [RD_PORTS-1:0]          rd_en,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS-1:0]          rd_valid,
  output logic [RD_PORTS*WIDTH-1:0]    rd_data,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  output logic                         err_oob,
  output logic                         err_collision,
  output logic [CNT_W-1:0]             rd_count,
  output logic [CNT_W-1:0]             wr_count
);

  localparam int unsigned PC_W  = $clog2(RD_PORTS + 1);
  localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [RD_LATENCY-1:0][RD_PORTS-1:0]            vld_q, vld_d;
  logic [RD_LATENCY-1:0][RD_PORTS-1:0][WIDTH-1:0] dat_q, dat_d;

  logic             err_oob_q, err_oob_d;
  logic             err_col_q, err_col_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  logic                           wr_in_range_c;
  logic [RD_PORTS-1:0]            rd_in_range_c;
  logic [RD_PORTS-1:0]            rd_hit_c;
  logic [RD_PORTS-1:0][WIDTH-1:0] rd_word_c;
  logic [PC_W-1:0]                rd_pop_c;
  logic [SUM_W-1:0]               rd_sum_c;

  // Address decode, same-address detection and read word selection
  always_comb begin
    wr_in_range_c = ({1'b0, wr_addr} < DEPTH_C);
    rd_in_range_c = '0;
    rd_hit_c      = '0;
    rd_word_c     = '0;
    rd_pop_c      = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_in_range_c[p] = ({1'b0, rd_addr[p*ADDR_W +: ADDR_W]} < DEPTH_C);
      rd_hit_c[p]      = rd_en[p] & wr_en & wr_in_range_c &
                         (rd_addr[p*ADDR_W +: ADDR_W] == wr_addr);
      if (rd_in_range_c[p]) begin
        rd_word_c[p] = mem_q[rd_addr[p*ADDR_W +: ADDR_W]];
      end
`ifdef MEMREF_MODEL_MP_BYPASS_EN
      if (rd_hit_c[p]) begin
        rd_word_c[p] = wr_data;
      end
`endif
      rd_pop_c = rd_pop_c + PC_W'(rd_en[p]);
    end
  end

  // Sticky flags and saturating counters; clr overrides same-edge events
  always_comb begin
    err_oob_d = err_oob_q | (wr_en & ~wr_in_range_c) | (|(rd_en & ~rd_in_range_c));
`ifdef MEMREF_MODEL_MP_BYPASS_EN
    err_col_d = err_col_q;
`else
    err_col_d = err_col_q | (|rd_hit_c);
`endif
    rd_sum_c = SUM_W'(rd_cnt_q) + SUM_W'(rd_pop_c);
    rd_cnt_d = (|rd_sum_c[SUM_W-1:CNT_W]) ? '1 : rd_sum_c[CNT_W-1:0];
    wr_cnt_d = wr_cnt_q;
    if (wr_en && wr_in_range_c && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
    if (clr) begin
      err_oob_d = 1'b0;
      err_col_d = 1'b0;
      rd_cnt_d  = '0;
      wr_cnt_d  = '0;
    end
  end

  // Read pipeline: data only advances with its valid, so idle stages keep the last word
  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = rd_en;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (rd_en[p]) begin
        dat_d[0][p] = rd_word_c[p];
      end
    end
    for (int s = 1; s < RD_LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      for (int p = 0; p < RD_PORTS; p++) begin
        if (vld_q[s-1][p]) begin
          dat_d[s][p] = dat_q[s-1][p];
        end
      end
    end
  end

  // Storage array is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range_c) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q     <= '0;
      dat_q     <= '0;
      err_oob_q <= 1'b0;
      err_col_q <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      vld_q     <= vld_d;
      dat_q     <= dat_d;
      err_oob_q <= err_oob_d;
      err_col_q <= err_col_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign rd_valid      = vld_q[RD_LATENCY-1];
  assign rd_data       = dat_q[RD_LATENCY-1];
  assign err_oob       = err_oob_q;
  assign err_collision = err_col_q;
  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;

endmodule

// File: doc/memref_model_mp.md
Name: memref_model_mp

Overview:
- Parametrised, clocked memory model for accelerator testbenches and small on-chip buffers.
- Supports N independent read ports, each with a configurable read-latency pipeline, and one write port.
- Includes sticky access-error detection and saturating access counters.
- Replaces separate single-port read/write memref models: one instance can serve a kernel's read and write ports on the same array.

Parameters:
- WIDTH, 32: data width in bits.
- DEPTH, 64: number of words; need not be a power of two.
- ADDR_W, 6: address width; must satisfy 2**ADDR_W >= DEPTH.
- RD_PORTS, 2: number of read ports, 1..8.
- RD_LATENCY, 1: cycles from rd_en sampled to rd_valid/rd_data; 1..4.
- CNT_W, 32: width of the access counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of counters and sticky error flags.
- rd_en  in  RD_PORTS  per-port read request.
- rd_addr  in  RD_PORTS*ADDR_W  packed read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- rd_valid  out  RD_PORTS  per-port read-data valid.
- rd_data  out  RD_PORTS*WIDTH  packed read data.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- err_oob  out  1  sticky: any access with address >= DEPTH.
- err_collision  out  1  sticky: read and write to the same in-range address in the same cycle.
- rd_count  out  CNT_W  total accepted read requests across all ports; saturating.
- wr_count  out  CNT_W  total accepted write requests; saturating.

Behaviour:
- Reset (rst low, asynchronous):
  - rd_valid, rd_data, all pipeline stages, err_oob, err_collision, rd_count and wr_count go to 0.
  - Memory array contents are not reset.
  - Reset asserted mid-read discards all in-flight reads; no rd_valid pulse appears after reset is released.
- Write:
  - At a rising edge with wr_en=1 and wr_addr<DEPTH, mem[wr_addr] <= wr_data and wr_count increments.
  - With wr_addr>=DEPTH the write is dropped, err_oob is set and wr_count does not increment.
- Read, per port p independently:
  - rd_en[p] sampled at edge k produces rd_valid[p]=1 and data at edge k+RD_LATENCY, held for exactly one cycle.
  - Fully pipelined: a new request is accepted every cycle.
  - Data is the array word at edge k, read-first with respect to a write at the same edge.
  - Address >= DEPTH: returns 0, sets err_oob, still counts as a read and still produces rd_valid.
  - Stage registers with valid=0 hold their data value; rd_data is undefined-free (last value) when rd_valid=0.
  - Multiple ports may read the same address in the same cycle with no error.
- rd_count:
  - Adds popcount(rd_en) each cycle.
  - Saturates at 2**CNT_W-1; an addition that would overflow clamps to the maximum.
- Collision:
  - Set when wr_en and any rd_en[p] target the same in-range address at the same edge.
  - The write still occurs.
- clr:
  - At the edge where clr=1, counters and flags go to 0.
  - Events at that same edge are not counted or flagged; clr wins.
  - clr does not affect the pipeline or the memory.
- Sticky flags remain set until clr or reset.

Optional Feature:
- Macro: MEMREF_MODEL_MP_BYPASS_EN.
- Defined: a same-edge read and write to the same in-range address returns wr_data (write-first forwarding) after RD_LATENCY, and err_collision is not set for that event.
- Undefined: read-first data is returned and err_collision is set, as described in Behaviour.

Test Plan:
- Reset, then write mem[5]=0x1234; at the next edge issue port0 read of addr 5 with RD_LATENCY=2 -> rd_valid[0] high exactly 2 cycles after sampling, rd_data[0]=0x1234, rd_count=1, wr_count=1.
- Back-to-back reads: port0 reads addresses 0..7 on consecutive cycles after writing mem[i]=i+1 -> eight consecutive rd_valid pulses returning data 1..8 in order.
- Same-edge collision: mem[3]=7, then wr_en with addr 3 and data 9 while port1 reads addr 3 -> macro undefined: data 7 and err_collision=1; macro defined: data 9 and err_collision=0; a later read of addr 3 returns 9 in both builds.
- Out of range with DEPTH=60: write to addr 62 -> err_oob=1, wr_count unchanged; read of addr 61 -> rd_valid=1, data 0; clr -> err_oob=0 and both counters 0.
- Reset mid-flight with RD_LATENCY=3: issue a read, drop rst after 1 cycle, release it -> no rd_valid pulse ever appears; memory contents are retained.
- Saturation with CNT_W=4: all RD_PORTS=2 ports read for 10 cycles -> rd_count stops at 15.
